// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake bundle for muldiv_unit
//   in_valid/in_ready, funct3, op_a, op_b  - request channel
//   flush                                  - abort in-flight operation
//   out_valid/out_ready, out_result, out_dz - result channel
interface muldiv_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready, flush, out_valid, out_ready, out_dz;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, out_result;
  modport master (output in_valid, funct3, op_a, op_b, flush, out_ready,
                  input in_ready, out_valid, out_result, out_dz);
  modport slave (input in_valid, funct3, op_a, op_b, flush, out_ready,
                 output in_ready, out_valid, out_result, out_dz);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide, one bit per cycle
//   clk, rst_n (async active-low), bus (muldiv_if.slave: request, flush, result)
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit SPECIAL_FAST = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;
  state_t            state, state_nx;
  logic [2:0]        f;
  logic [XLEN-1:0]   a, b, res, ma, mb, q, r, adj;
  logic [2*XLEN-1:0] prod, pn, step;
  logic [XLEN:0]     sum, shl, diff;
  logic [CW-1:0]     cnt;
  logic              dz, a_neg, b_neg;

  function automatic logic sgn_a(input logic [2:0] fn);
    return !(fn inside {3'b011, 3'b101, 3'b111});
  endfunction

  function automatic logic sgn_b(input logic [2:0] fn);
    return fn inside {3'b000, 3'b001, 3'b100, 3'b110};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  // divide by zero, or signed most-negative / -1
  function automatic logic special(input logic [2:0] fn, input logic [XLEN-1:0] x, y);
    return fn[2] && (y == '0 || (!fn[0] && x == {1'b1, {(XLEN-1){1'b0}}} && y == '1));
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic [2:0] fn, input logic [XLEN-1:0] x, y);
    return (y == '0) ? (fn[1] ? x : '1) : (fn[1] ? '0 : x);
  endfunction

  assign a_neg = sgn_a(f) && a[XLEN-1];
  assign b_neg = sgn_b(f) && b[XLEN-1];
  assign ma    = mag(a, sgn_a(f));
  assign mb    = mag(b, sgn_b(f));
  // multiply: add multiplicand into the upper half when the multiplier lsb is set, then shift right
  assign sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, ma} : '0);
  // divide: prod holds {remainder, dividend/quotient}; shift left and trial-subtract
  assign shl   = prod[2*XLEN-1:XLEN-1];
  assign diff  = shl - {1'b0, mb};
  assign step  = !f[2] ? {sum, prod[XLEN-1:1]} :
                 diff[XLEN] ? {shl[XLEN-1:0], prod[XLEN-2:0], 1'b0} :
                              {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
  assign pn    = (a_neg ^ b_neg) ? -prod : prod;
  assign q     = (a_neg ^ b_neg) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign r     = a_neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
  assign adj   = special(f, a, b) ? special_res(f, a, b) :
                 f[2] ? (f[1] ? r : q) :
                 (f[1:0] == 2'b00) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = IDLE;
    else
      case (state)
        IDLE: if (bus.in_valid)
                state_nx = (SPECIAL_FAST && special(bus.funct3, bus.op_a, bus.op_b)) ? DONE : CALC;
        CALC: if (cnt == '0) state_nx = ADJ;
        ADJ:  state_nx = DONE;
        DONE: if (bus.out_ready) state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f    <= '0;
      a    <= '0;
      b    <= '0;
      prod <= '0;
      res  <= '0;
      cnt  <= '0;
      dz   <= 1'b0;
    end else if (state == IDLE && bus.in_valid && !bus.flush) begin
      f    <= bus.funct3;
      a    <= bus.op_a;
      b    <= bus.op_b;
      cnt  <= CW'(XLEN - 1);
      prod <= {{XLEN{1'b0}}, bus.funct3[2] ? mag(bus.op_a, sgn_a(bus.funct3))
                                          : mag(bus.op_b, sgn_b(bus.funct3))};
      res  <= special_res(bus.funct3, bus.op_a, bus.op_b);
      dz   <= bus.funct3[2] && bus.op_b == '0;
    end else if (state == CALC) begin
      prod <= step;
      cnt  <= (cnt == '0) ? cnt : cnt - CW'(1);
    end else if (state == ADJ) res <= adj;

  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == DONE;
  assign bus.out_result = bus.out_valid ? res : '0;
  assign bus.out_dz     = bus.out_valid && dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (XLEN=32, SPECIAL_FAST=1)
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   lat;

  muldiv_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3   = fn;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct3   = ~fn;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic wait_valid(output int l);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    l = n + 1;
  endtask

  task automatic consume;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_res, input logic exp_dz, input int exp_lat);
    int l;
    start(fn, a, b);
    wait_valid(l);
    chk({tag, "_res"}, bus.out_result, exp_res);
    chk({tag, "_dz"}, 32'(bus.out_dz), 32'(exp_dz));
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    consume;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_dz", 32'(bus.out_dz), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    op("mul_neg", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34);
    op("mul_m1m1", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 34);
    op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
    op("mulh_m1m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34);
    op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
    op("mulhsu_min", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);
    op("mulhu_pow", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34);
    op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34);
    op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
    op("divu_big", 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 1'b0, 34);
    op("remu_small", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 34);
    op("divu_dz", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1);
    op("remu_dz", 3'b111, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    op("div_dz_neg", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1, 1);
    op("rem_dz_neg", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b1, 1);
    op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
    op("divu_noovf", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34);

    start(3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    chk("hold_lat", 32'(lat), 32'd34);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", bus.out_result, 32'd14);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("consume_out_valid", 32'(bus.out_valid), 32'd0);
    chk("consume_in_ready", 32'(bus.in_ready), 32'd1);

    start(3'b000, 32'h12345, 32'h777);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("calc_result_zero", bus.out_result, 32'd0);
    chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) seen++;
      end
      chk("flush_no_valid", 32'(seen), 32'd0);
    end

    start(3'b101, 32'd5, 32'd0);
    chk("dflush_pre_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    chk("dflush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("dflush_in_ready", 32'(bus.in_ready), 32'd1);

    start(3'b000, 32'h1234, 32'd5);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_result", bus.out_result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) seen++;
      end
      chk("arst_no_valid", 32'(seen), 32'd0);
    end
    op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values are even integers from 8 to 64.
REQ-002 Parameter SPECIAL_FAST, default 1: when 1, divide-by-zero and signed overflow complete early.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-010 flush  input  1  abort the in-flight operation (pipeline squash).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_result  output  XLEN  operation result.
REQ-014 out_dz  output  1  divisor was zero (DIV/DIVU/REM/REMU only).

Function
REQ-015 State machine SHALL have states IDLE, CALC, ADJ and DONE; one-hot or binary encoding is allowed.
REQ-016 IDLE: when in_valid is 1, SHALL latch funct3, op_a and op_b, and go to CALC (or to DONE per REQ-021); in_ready=1 only in IDLE.
REQ-017 Operands SHALL be captured only on the accepting edge; input changes after that edge SHALL have no effect.
REQ-018 CALC multiply: iterative shift-add on magnitudes, one bit per cycle, exactly XLEN cycles, with a 2*XLEN-bit product register.
- MUL, MULH: both operands signed.
- MULHSU: op_a signed, op_b unsigned.
- MULHU: both unsigned.
REQ-019 CALC divide: restoring division on magnitudes, one quotient bit per cycle, exactly XLEN cycles; DIV/REM are signed, DIVU/REMU unsigned.
REQ-020 ADJ, one cycle, applies sign correction:
- product negated if the operand signs differ;
- quotient negated if the dividend and divisor signs differ;
- remainder takes the dividend's sign;
- result selected: MUL gives the low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits.
REQ-021 Special cases, when SPECIAL_FAST=1, go IDLE to DONE directly, bypassing CALC/ADJ:
- divisor=0: quotient all-ones, remainder = op_a, out_dz=1;
- DIV/REM with op_a = most-negative and op_b = all-ones: quotient = op_a, remainder = 0.
REQ-022 Special cases when SPECIAL_FAST=0: same results as REQ-021, but with the normal XLEN+2 latency.
REQ-023 Normal latency: out_valid SHALL first be high XLEN+2 cycles after the accepting edge; fast-special latency is 1 cycle.
REQ-024 DONE: out_valid=1, and out_result/out_dz SHALL be held stable until out_valid and out_ready are both 1 on a clock edge; the next state is then IDLE.
REQ-025 No new request SHALL be accepted in the same cycle as a result is consumed; back-to-back throughput is one operation per XLEN+3 cycles.
REQ-026 flush=1 on an edge SHALL send any state to IDLE with out_valid=0; this includes DONE, where the result is discarded.
REQ-027 flush SHALL take priority over in_valid and out_ready.
REQ-028 Outside DONE, out_valid=0, out_dz=0 and out_result=0.
REQ-029 An internal iteration counter of ceil(log2(XLEN))+1 bits SHALL count XLEN-1 down to 0 and SHALL not wrap.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock, force IDLE, out_valid=0, out_result=0, out_dz=0 and clear the counter and data registers; in_ready=1 once reset is applied.
REQ-031 Reset asserted mid-CALC SHALL discard the operation; no out_valid may follow reset release.

Verification (XLEN=32, SPECIAL_FAST=1)
REQ-032 MUL op_a=7, op_b=0xFFFFFFFD -> out_result=0xFFFFFFEB; out_valid exactly 34 cycles after acceptance.
REQ-033 MULHU op_a=op_b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF with out_dz=1, 1-cycle latency; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_result stable and in_ready=0 throughout; on the consuming edge, in_ready=1 the next cycle.
REQ-037 flush on the 10th CALC cycle -> IDLE next cycle with no out_valid; rst_n pulsed low mid-CALC -> out_valid=0 asynchronously, then a fresh MUL 3*4 -> 12.
